// File: rtl/ball_ctl.sv
// Pong ball physics: moves the ball once per frame, bounces off walls and pads, reports points.
// Optional BALL_SPEEDUP_EN adds the hit counter that raises the x-speed every few pad hits.
module ball_ctl #(
    parameter int FIELD_W          = 1024,
    parameter int FIELD_H          = 768,
    parameter int BALL_SIZE        = 15,
    parameter int PAD_HEIGHT       = 145,
    parameter int PAD_WIDTH        = 15,
    parameter int X_PAD_LEFT       = 30,
    parameter int X_PAD_RIGHT      = 979,
    parameter int SPEED_INIT       = 4,
    parameter int SPEED_MAX        = 8,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int HOLD_FRAMES      = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        serve,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_ball,
    output logic [9:0]  y_ball,
    output logic        ball_active,
    output logic        score_left_evt,
    output logic        score_right_evt
);

    // state  | meaning
    // IDLE   | ball centred, waiting for a serve
    // PLAY   | ball moving, walls and pads active
    // SCORED | ball frozen at the edge for HOLD_FRAMES frames
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } state_t;

    localparam int SP_W   = $clog2(SPEED_MAX + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [11:0] C_BALL  = 12'(BALL_SIZE);
    localparam logic [11:0] C_FW_M1 = 12'(FIELD_W - 1);
    localparam logic [11:0] C_FH_M1 = 12'(FIELD_H - 1);
    localparam logic [11:0] C_PH    = 12'(PAD_HEIGHT);
    localparam logic [11:0] C_XPR   = 12'(X_PAD_RIGHT);
    localparam logic [11:0] C_FACEL = 12'(X_PAD_LEFT + PAD_WIDTH);
    localparam logic [11:0] C_SY    = 12'(SPEED_INIT);

    localparam logic [10:0] X_CTR   = 11'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CTR   = 10'((FIELD_H - BALL_SIZE) / 2);
    localparam logic [10:0] X_LAND_R = 11'(X_PAD_RIGHT - BALL_SIZE - 1);
    localparam logic [10:0] X_LAND_L = 11'(X_PAD_LEFT + PAD_WIDTH + 1);
    localparam logic [10:0] X_MISS_R = 11'(FIELD_W - 1 - BALL_SIZE);
    localparam logic [9:0]  Y_BOTTOM = 10'(FIELD_H - 1 - BALL_SIZE);

    if (HITS_PER_SPEEDUP < 1 || SPEED_MAX < SPEED_INIT) begin : g_bad_cfg
        $error("ball_ctl: inconsistent speed configuration");
    end

    state_t              state, state_nxt;
    logic                vblnk_q, tick;
    logic                dir_x, dir_x_nxt;       // 1 = right
    logic                dir_y, dir_y_nxt;       // 1 = down
    logic                serve_dir, serve_dir_nxt;
    logic                pending, pending_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [10:0]         x_nxt;
    logic [9:0]          y_nxt;
    logic                sl_nxt, sr_nxt;
    logic [SP_W-1:0]     speed_x;
    logic [SP_W-1:0]     eff_sx;
    logic                eff_dx, eff_dy, move, pad_hit;
    logic [11:0]         x12, y12, sx12, pad_l12, pad_r12;
    logic                ovl_l, ovl_r;

`ifdef BALL_SPEEDUP_EN
    localparam int HIT_W = $clog2(HITS_PER_SPEEDUP + 1);
    logic [HIT_W-1:0]    hit_cnt, hit_cnt_nxt, eff_hc;
    logic [SP_W-1:0]     speed_x_nxt;
`else
    assign speed_x = SP_W'(SPEED_INIT);
`endif

    assign tick        = vblnk & ~vblnk_q;
    assign ball_active = (state == PLAY);

    assign x12     = {1'b0, x_ball};
    assign y12     = {2'b0, y_ball};
    assign pad_l12 = {2'b0, y_pad_left};
    assign pad_r12 = {2'b0, y_pad_right};
    assign ovl_l   = (y12 + C_BALL >= pad_l12) && (y12 <= pad_l12 + C_PH);
    assign ovl_r   = (y12 + C_BALL >= pad_r12) && (y12 <= pad_r12 + C_PH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            vblnk_q         <= 1'b0;
            x_ball          <= X_CTR;
            y_ball          <= Y_CTR;
            dir_x           <= 1'b1;
            dir_y           <= 1'b1;
            serve_dir       <= 1'b1;
            pending         <= 1'b0;
            hold_cnt        <= '0;
            score_left_evt  <= 1'b0;
            score_right_evt <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_x         <= SP_W'(SPEED_INIT);
            hit_cnt         <= '0;
`endif
        end else begin
            state           <= state_nxt;
            vblnk_q         <= vblnk;
            x_ball          <= x_nxt;
            y_ball          <= y_nxt;
            dir_x           <= dir_x_nxt;
            dir_y           <= dir_y_nxt;
            serve_dir       <= serve_dir_nxt;
            pending         <= pending_nxt;
            hold_cnt        <= hold_nxt;
            score_left_evt  <= sl_nxt;
            score_right_evt <= sr_nxt;
`ifdef BALL_SPEEDUP_EN
            speed_x         <= speed_x_nxt;
            hit_cnt         <= hit_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        x_nxt         = x_ball;
        y_nxt         = y_ball;
        dir_x_nxt     = dir_x;
        dir_y_nxt     = dir_y;
        serve_dir_nxt = serve_dir;
        pending_nxt   = 1'b0;
        hold_nxt      = hold_cnt;
        sl_nxt        = 1'b0;
        sr_nxt        = 1'b0;
        move          = 1'b0;
        pad_hit       = 1'b0;
        eff_dx        = dir_x;
        eff_dy        = dir_y;
        eff_sx        = speed_x;
`ifdef BALL_SPEEDUP_EN
        speed_x_nxt   = speed_x;
        hit_cnt_nxt   = hit_cnt;
        eff_hc        = hit_cnt;
`endif

        case (state)
            IDLE: begin
                pending_nxt = pending | serve;
                // The serve frame also carries the first movement step.
                if (tick && (pending || serve)) begin
                    state_nxt     = PLAY;
                    pending_nxt   = 1'b0;
                    serve_dir_nxt = ~serve_dir;
                    eff_dx        = serve_dir;
                    eff_dy        = 1'b1;
                    eff_sx        = SP_W'(SPEED_INIT);
`ifdef BALL_SPEEDUP_EN
                    eff_hc        = '0;
`endif
                    move          = 1'b1;
                end
            end
            PLAY: begin
                move = tick;
            end
            SCORED: begin
                if (tick) begin
                    if (hold_cnt == '0) begin
                        state_nxt = IDLE;
                        x_nxt     = X_CTR;
                        y_nxt     = Y_CTR;
                    end else begin
                        hold_nxt = hold_cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        sx12 = 12'(eff_sx);

        if (move) begin
            dir_x_nxt = eff_dx;
            dir_y_nxt = eff_dy;
`ifdef BALL_SPEEDUP_EN
            speed_x_nxt = eff_sx;
            hit_cnt_nxt = eff_hc;
`endif
            if (eff_dy) begin
                if (y12 + C_BALL + C_SY >= C_FH_M1) begin
                    y_nxt     = Y_BOTTOM;
                    dir_y_nxt = 1'b0;
                end else begin
                    y_nxt = 10'(y12 + C_SY);
                end
            end else begin
                if (y12 <= C_SY) begin
                    y_nxt     = '0;
                    dir_y_nxt = 1'b1;
                end else begin
                    y_nxt = 10'(y12 - C_SY);
                end
            end

            // A hit needs the leading edge to cross the pad face on this frame.
            if (eff_dx) begin
                if ((x12 + C_BALL < C_XPR) && (x12 + C_BALL + sx12 >= C_XPR) && ovl_r) begin
                    x_nxt     = X_LAND_R;
                    dir_x_nxt = 1'b0;
                    pad_hit   = 1'b1;
                end else if (x12 + C_BALL + sx12 >= C_FW_M1) begin
                    x_nxt     = X_MISS_R;
                    sl_nxt    = 1'b1;
                    state_nxt = SCORED;
                    hold_nxt  = HOLD_W'(HOLD_FRAMES - 1);
                end else begin
                    x_nxt = 11'(x12 + sx12);
                end
            end else begin
                if ((x12 > C_FACEL) && (x12 <= C_FACEL + sx12) && ovl_l) begin
                    x_nxt     = X_LAND_L;
                    dir_x_nxt = 1'b1;
                    pad_hit   = 1'b1;
                end else if (x12 <= sx12) begin
                    x_nxt     = '0;
                    sr_nxt    = 1'b1;
                    state_nxt = SCORED;
                    hold_nxt  = HOLD_W'(HOLD_FRAMES - 1);
                end else begin
                    x_nxt = 11'(x12 - sx12);
                end
            end

`ifdef BALL_SPEEDUP_EN
            if (pad_hit) begin
                if (eff_hc == HIT_W'(HITS_PER_SPEEDUP - 1)) begin
                    hit_cnt_nxt = '0;
                    if (eff_sx < SP_W'(SPEED_MAX)) begin
                        speed_x_nxt = eff_sx + 1'b1;
                    end
                end else begin
                    hit_cnt_nxt = eff_hc + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ball_ctl.sv
// Directed bench for ball_ctl: vector table for the main scenarios, hand sequences for
// asynchronous reset and a long pad rally that exercises the speed steps.
module tb_ball_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk = 1'b0;
    logic        serve = 1'b0;
    logic [9:0]  y_pad_left = '0;
    logic [9:0]  y_pad_right = '0;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic        ball_active;
    logic        score_left_evt;
    logic        score_right_evt;

    int n_vec = 0;
    int n_bad = 0;

`ifdef BALL_SPEEDUP_EN
    localparam int STEP_AFTER4  = 5;
    localparam int STEP_AFTER16 = 8;
`else
    localparam int STEP_AFTER4  = 4;
    localparam int STEP_AFTER16 = 4;
`endif

    ball_ctl dut (
        .clk             (clk),
        .rst             (rst),
        .vblnk           (vblnk),
        .serve           (serve),
        .y_pad_left      (y_pad_left),
        .y_pad_right     (y_pad_right),
        .x_ball          (x_ball),
        .y_ball          (y_ball),
        .ball_active     (ball_active),
        .score_left_evt  (score_left_evt),
        .score_right_evt (score_right_evt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit do_rst;
        bit do_serve;
        int pad_r;
        int ticks;
        int ex;
        int ey;
        bit ea;
        bit esl;
        bit esr;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: vblnk rises at a negedge, the tick edge follows, ends one negedge later.
    task automatic tick();
        @(negedge clk);
        vblnk = 1'b1;
        @(negedge clk);
        vblnk = 1'b0;
    endtask

    task automatic serve_pulse();
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int  mx, ms, mhc, hits, prev, d;
    bit  mdir, hit, c4, c16, c3, any_evt;

    initial begin
        //          rst srv pad  ticks  x     y    act sl sr
        vecs[0]  = '{1, 0, 600,   0,  504,  376, 0, 0, 0};
        vecs[1]  = '{0, 1, 600,   1,  508,  380, 1, 0, 0};
        vecs[2]  = '{0, 1, 600,   1,  512,  384, 1, 0, 0};
        vecs[3]  = '{0, 0, 600,  91,  876,  748, 1, 0, 0};
        vecs[4]  = '{0, 0, 600,   1,  880,  752, 1, 0, 0};
        vecs[5]  = '{0, 0, 600,   1,  884,  748, 1, 0, 0};
        vecs[6]  = '{0, 0, 600,  19,  960,  672, 1, 0, 0};
        vecs[7]  = '{0, 0, 600,   1,  963,  668, 1, 0, 0};
        vecs[8]  = '{0, 0, 600,   1,  959,  664, 1, 0, 0};
        vecs[9]  = '{1, 1,   0, 115,  964,  668, 1, 0, 0};
        vecs[10] = '{0, 0,   0,  10, 1004,  628, 1, 0, 0};
        vecs[11] = '{0, 0,   0,   1, 1008,  624, 0, 1, 0};
        vecs[12] = '{0, 1,   0,  59, 1008,  624, 0, 0, 0};
        vecs[13] = '{0, 0,   0,   1,  504,  376, 0, 0, 0};
        vecs[14] = '{0, 0,   0,   1,  504,  376, 0, 0, 0};
        vecs[15] = '{0, 1,   0,   1,  500,  380, 1, 0, 0};

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].do_rst) do_reset();
            y_pad_right = 10'(vecs[i].pad_r);
            y_pad_left  = '0;
            if (vecs[i].do_serve) serve_pulse();
            for (int k = 0; k < vecs[i].ticks; k++) tick();
            check($sformatf("v%0d_x", i), int'(x_ball), vecs[i].ex);
            check($sformatf("v%0d_y", i), int'(y_ball), vecs[i].ey);
            check($sformatf("v%0d_active", i), int'(ball_active), int'(vecs[i].ea));
            check($sformatf("v%0d_score_left", i), int'(score_left_evt), int'(vecs[i].esl));
            check($sformatf("v%0d_score_right", i), int'(score_right_evt), int'(vecs[i].esr));
            @(negedge clk);
            check($sformatf("v%0d_score_left_next", i), int'(score_left_evt), 0);
            check($sformatf("v%0d_score_right_next", i), int'(score_right_evt), 0);
        end

        // Asynchronous reset in the middle of play, with a vblnk edge while held.
        do_reset();
        y_pad_right = 10'd600;
        serve_pulse();
        repeat (5) tick();
        check("rst_pre_x", int'(x_ball), 524);
        check("rst_pre_y", int'(y_ball), 396);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_x", int'(x_ball), 504);
        check("rst_async_y", int'(y_ball), 376);
        check("rst_async_active", int'(ball_active), 0);
        check("rst_async_evt", int'(score_left_evt | score_right_evt), 0);
        @(negedge clk);
        vblnk = 1'b1;
        repeat (2) @(negedge clk);
        vblnk = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hold_x", int'(x_ball), 504);
        check("rst_hold_y", int'(y_ball), 376);
        tick();
        check("rst_idle_x", int'(x_ball), 504);
        check("rst_idle_active", int'(ball_active), 0);

        // Rally: both pads follow the ball so every face crossing is a hit.
        do_reset();
        serve_pulse();
        mx = 504; mdir = 1'b1; ms = 4; mhc = 0; hits = 0;
        c3 = 0; c4 = 0; c16 = 0; any_evt = 0;
        for (int t = 0; t < 6000 && hits < 17; t++) begin
            prev = int'(x_ball);
            y_pad_left  = y_ball;
            y_pad_right = y_ball;
            tick();
            any_evt |= score_left_evt | score_right_evt;
            hit = 1'b0;
            if (mdir) begin
                if (mx + 15 < 979 && mx + 15 + ms >= 979) begin
                    mx = 963; mdir = 1'b0; hit = 1'b1;
                end else if (mx + 15 + ms >= 1023) mx = 1008;
                else mx = mx + ms;
            end else begin
                if (mx > 45 && mx - ms <= 45) begin
                    mx = 46; mdir = 1'b1; hit = 1'b1;
                end else if (mx <= ms) mx = 0;
                else mx = mx - ms;
            end
            if (hit) begin
                hits++;
`ifdef BALL_SPEEDUP_EN
                mhc++;
                if (mhc == 4) begin
                    mhc = 0;
                    if (ms < 8) ms++;
                end
`endif
            end
            check("rally_x", int'(x_ball), mx);
            if (int'(x_ball) != mx) break;
            d = int'(x_ball) - prev;
            if (d < 0) d = -d;
            if (!hit && hits == 3 && !c3) begin
                check("rally_step_hit3", d, 4);
                c3 = 1'b1;
            end
            if (!hit && hits == 4 && !c4) begin
                check("rally_step_hit4", d, STEP_AFTER4);
                c4 = 1'b1;
            end
            if (!hit && hits == 16 && !c16) begin
                check("rally_step_hit16", d, STEP_AFTER16);
                c16 = 1'b1;
            end
        end
        check("rally_hits", hits, 17);
        check("rally_no_score", int'(any_evt), 0);
        check("rally_active", int'(ball_active), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
